mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the multicycle RV32I core between two requesters:
  - instruction fetch, driven during FETCH_S1;
  - load/store data access, driven during EXECUTE_S3 / WRITEBACK_S4.
- Sits between the control unit / LSU and the memory wrapper.
- One outstanding transaction at a time, with a req/gnt/rvalid handshake on each side and req/ack on the memory side.

---
 rtl/fe_pkg.sv | 27 ++
 rtl/mem_arb_timeout_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared types, constants and register macros for the front-end memory port arbiter.
// The register macro assumes a clock named clk and an active-low synchronous reset named rst.
`ifndef FF_D_RST_EN
`define FF_D_RST_EN(q_, d_, en_, rv_) \
    always_ff @(posedge clk) begin \
        if (!rst) q_ <= (rv_); \
        else if (en_) q_ <= (d_); \
    end
`endif

package fe_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2,
        ARB_RESP   = 2'd3
    } MEM_ARB_FSM_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } MEM_ARB_OWNER_t;

    localparam logic [31:0] MEM_ARB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// Busy-cycle counter for the memory port arbiter; flags expiry in the cycle
// the TIMEOUT_CYCLES-th busy cycle passes without an ack.
module mem_arb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt_reg <= '0;
        end else if (busy && !ack) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // An ack in the expiry cycle takes precedence over the abort.
    assign expired = busy && !ack && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store.
// Optional busy timeout with sticky error is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import fe_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                err_o
);
    MEM_ARB_FSM_t   state_reg, state_next;
    MEM_ARB_OWNER_t prio_reg, prio_next;
    MEM_ARB_OWNER_t owner_reg, owner_next;

    logic                we_reg, we_next;
    logic [DATA_W/8-1:0] be_reg, be_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   if_rdata_reg, d_rdata_reg, rdata_next;

    logic grant;
    logic in_busy;
    logic cap_en;
    logic timeout_hit;

    assign in_busy = (state_reg == ARB_I_BUSY) || (state_reg == ARB_D_BUSY);

    always_comb begin
        state_next = state_reg;
        if_gnt_o   = 1'b0;
        d_gnt_o    = 1'b0;
        cap_en     = 1'b0;

        // Grants are gated by rst so nothing is accepted while reset is held.
        if (rst && state_reg == ARB_IDLE) begin
            if (d_req_i && (!if_req_i || prio_reg == OWNER_D)) begin
                d_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end

        case (state_reg)
            ARB_IDLE: begin
                if (d_gnt_o)       state_next = ARB_D_BUSY;
                else if (if_gnt_o) state_next = ARB_I_BUSY;
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (mem_ack_i || timeout_hit) begin
                    cap_en     = 1'b1;
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    assign grant      = if_gnt_o || d_gnt_o;
    // The priority bit always points at whoever did not just win.
    assign prio_next  = d_gnt_o ? OWNER_IF : OWNER_D;
    assign owner_next = d_gnt_o ? OWNER_D : OWNER_IF;
    assign we_next    = d_gnt_o ? d_we_i : 1'b0;
    assign be_next    = d_gnt_o ? d_be_i : '1;
    assign addr_next  = d_gnt_o ? d_addr_i : if_addr_i;
    assign wdata_next = d_gnt_o ? d_wdata_i : '0;

    always_comb begin
        rdata_next = mem_rdata_i;
        if (!mem_ack_i && timeout_hit) rdata_next = DATA_W'(MEM_ARB_ERR_DATA);
        else if (we_reg)               rdata_next = '0;
    end

    `FF_D_RST_EN(state_reg, state_next, 1'b1, ARB_IDLE)
    `FF_D_RST_EN(prio_reg, prio_next, grant, OWNER_D)
    `FF_D_RST_EN(owner_reg, owner_next, grant, OWNER_IF)
    `FF_D_RST_EN(we_reg, we_next, grant, 1'b0)
    `FF_D_RST_EN(be_reg, be_next, grant, '0)
    `FF_D_RST_EN(addr_reg, addr_next, grant, '0)
    `FF_D_RST_EN(wdata_reg, wdata_next, grant, '0)
    `FF_D_RST_EN(if_rdata_reg, rdata_next, cap_en && owner_reg == OWNER_IF, '0)
    `FF_D_RST_EN(d_rdata_reg, rdata_next, cap_en && owner_reg == OWNER_D, '0)

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_reg;

    mem_arb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant),
        .busy   (in_busy),
        .ack    (mem_ack_i),
        .expired(timeout_hit)
    );

    `FF_D_RST_EN(err_reg, 1'b1, timeout_hit, 1'b0)
    assign err_o = err_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    assign mem_req_o   = in_busy;
    assign mem_we_o    = we_reg;
    assign mem_be_o    = be_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != ARB_IDLE);
    assign if_rvalid_o = (state_reg == ARB_RESP) && (owner_reg == OWNER_IF);
    assign d_rvalid_o  = (state_reg == ARB_RESP) && (owner_reg == OWNER_D);
    assign if_rdata_o  = if_rdata_reg;
    assign d_rdata_o   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, arbitration, reset, stray/immediate ack,
// and timeout (MEM_ARB_TIMEOUT_EN) or indefinite wait (default build).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h44; d_req_i = 1'b1; d_we_i = 1'b0;
        d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        next_cycle(); next_cycle(); sample();
        n_checks++; if (if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt_o); end
        n_checks++; if (d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt_o); end
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_checks++; if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata_o, d_rdata_o); end
        n_checks++; if (mem_addr_o !== 32'h0 || mem_be_o !== 4'h0) begin n_fail++; $display("FAIL reset_mem_fields got=%h/%h exp=0/0", mem_addr_o, mem_be_o); end
        next_cycle();
        if_req_i = 1'b0; d_req_i = 1'b0; rst = 1'b1;
        sample();
        $display("reset applied and released");
    endtask

    task automatic test_fetch_read();
        next_cycle(); if_req_i = 1'b1; if_addr_i = 32'h100; sample();
        n_checks++; if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt got=%b/%b exp=1/0", if_gnt_o, d_gnt_o); end
        next_cycle(); if_req_i = 1'b0; sample();
        n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF)
            begin n_fail++; $display("FAIL fetch_mem_c1 got req=%b addr=%h we=%b be=%h exp 1/100/0/f", mem_req_o, mem_addr_o, mem_we_o, mem_be_o); end
        next_cycle(); sample();
        n_checks++; if (mem_req_o !== 1'b1 || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fetch_c2 got req=%b rv=%b exp=1/0", mem_req_o, if_rvalid_o); end
        next_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h00500093; sample();
        n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ack_cycle_req got=%b exp=1", mem_req_o); end
        next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
        n_checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h00500093) begin n_fail++; $display("FAIL fetch_rvalid got rv=%b data=%h exp=1/00500093", if_rvalid_o, if_rdata_o); end
        n_checks++; if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b0 || if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_side got req=%b drv=%b gnt=%b exp=0/0/0", mem_req_o, d_rvalid_o, if_gnt_o); end
        next_cycle(); sample();
        n_checks++; if (if_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL fetch_done got rv=%b busy=%b exp=0/0", if_rvalid_o, busy_o); end
        $display("fetch addr=00000100 data=%h", if_rdata_o);
    endtask

    task automatic test_store();
        next_cycle(); d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h2004; d_wdata_i = 32'hCAFE1234; sample();
        n_checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL store_gnt got=%b/%b exp=1/0", d_gnt_o, if_gnt_o); end
        next_cycle(); d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_wdata_i = 32'h0; sample();
        n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 || mem_addr_o !== 32'h2004 || mem_wdata_o !== 32'hCAFE1234)
            begin n_fail++; $display("FAIL store_mem got req=%b we=%b be=%h addr=%h wd=%h exp 1/1/3/2004/cafe1234", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
        next_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678; sample();
        next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
        n_checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h0 || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL store_resp got drv=%b data=%h irv=%b exp=1/0/0", d_rvalid_o, d_rdata_o, if_rvalid_o); end
        n_checks++; if (if_rdata_o !== 32'h00500093) begin n_fail++; $display("FAIL if_rdata_hold got=%h exp=00500093", if_rdata_o); end
        next_cycle(); sample();
        $display("store addr=00002004 wdata=cafe1234 be=3");
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_d;
        exp_d = 4'b0101;  // iteration 0 -> D, 1 -> IF, 2 -> D, 3 -> IF
        // Fresh reset so the priority bit starts at data.
        next_cycle(); rst = 1'b0; next_cycle(); rst = 1'b1;
        if_addr_i = 32'h200; d_addr_i = 32'h300; d_we_i = 1'b0; d_be_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin if_req_i = 1'b1; d_req_i = 1'b1; end
            else next_cycle();
            sample();
            n_checks++; if (d_gnt_o !== exp_d[i] || if_gnt_o !== !exp_d[i]) begin n_fail++; $display("FAIL simul_gnt[%0d] got d=%b if=%b exp d=%b if=%b", i, d_gnt_o, if_gnt_o, exp_d[i], !exp_d[i]); end
            next_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'hA000 + i; sample();
            n_checks++; if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || mem_addr_o !== (exp_d[i] ? 32'h300 : 32'h200))
                begin n_fail++; $display("FAIL simul_busy[%0d] got gnt=%b/%b addr=%h", i, if_gnt_o, d_gnt_o, mem_addr_o); end
            next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
            n_checks++; if (d_rvalid_o !== exp_d[i] || if_rvalid_o !== !exp_d[i] || if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0)
                begin n_fail++; $display("FAIL simul_resp[%0d] got drv=%b irv=%b gnt=%b/%b", i, d_rvalid_o, if_rvalid_o, if_gnt_o, d_gnt_o); end
            $display("simultaneous grant %0d -> %s", i, exp_d[i] ? "D" : "IF");
        end
        n_checks++; if (d_rdata_o !== 32'hA002 || if_rdata_o !== 32'hA003) begin n_fail++; $display("FAIL simul_rdata got d=%h if=%h exp=a002/a003", d_rdata_o, if_rdata_o); end
        next_cycle(); if_req_i = 1'b0; d_req_i = 1'b0; sample();
        n_checks++; if (busy_o !== 1'b0 || if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL simul_idle got busy=%b gnt=%b/%b exp=0/0/0", busy_o, if_gnt_o, d_gnt_o); end
    endtask

    task automatic test_stray_and_immediate_ack();
        next_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; sample();
        next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
        n_checks++; if (busy_o !== 1'b0 || if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0 || mem_req_o !== 1'b0)
            begin n_fail++; $display("FAIL stray_ack got busy=%b irv=%b drv=%b req=%b exp=0/0/0/0", busy_o, if_rvalid_o, d_rvalid_o, mem_req_o); end
        n_checks++; if (d_rdata_o !== 32'hA002) begin n_fail++; $display("FAIL stray_ack_rdata got=%h exp=a002", d_rdata_o); end
        $display("stray ack ignored");
        next_cycle(); if_req_i = 1'b1; if_addr_i = 32'h400; sample();
        n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL imm_gnt got=%b exp=1", if_gnt_o); end
        next_cycle(); if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h13; sample();
        n_checks++; if (if_rvalid_o !== 1'b0 || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL imm_c1 got rv=%b req=%b exp=0/1", if_rvalid_o, mem_req_o); end
        next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
        n_checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL imm_c2 got rv=%b data=%h req=%b exp=1/13/0", if_rvalid_o, if_rdata_o, mem_req_o); end
        next_cycle(); sample();
        $display("immediate ack fetch addr=00000400 data=%h", if_rdata_o);
    endtask

    task automatic test_timeout();
        next_cycle(); d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h40; sample();
        n_checks++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL tmo_gnt got=%b exp=1", d_gnt_o); end
        next_cycle(); d_req_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            sample();
            n_checks++; if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_busy[%0d] got req=%b err=%b exp=1/0", c, mem_req_o, err_o); end
            next_cycle();
        end
        sample();
        n_checks++; if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF || err_o !== 1'b1)
            begin n_fail++; $display("FAIL tmo_expire got req=%b drv=%b data=%h err=%b exp=0/1/deadbeef/1", mem_req_o, d_rvalid_o, d_rdata_o, err_o); end
        next_cycle(); sample();
        next_cycle(); if_req_i = 1'b1; if_addr_i = 32'h500; sample();
        next_cycle(); if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h77; sample();
        next_cycle(); mem_ack_i = 1'b0; sample();
        n_checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h77 || err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got rv=%b data=%h err=%b exp=1/77/1", if_rvalid_o, if_rdata_o, err_o); end
        next_cycle(); sample();
        $display("timeout load addr=00000040 data=%h err=%b", d_rdata_o, err_o);
`else
        begin
            int drops;
            drops = 0;
            for (int c = 1; c <= 120; c++) begin
                sample();
                if (mem_req_o !== 1'b1 || err_o !== 1'b0 || d_rvalid_o !== 1'b0) drops++;
                next_cycle();
            end
            n_checks++; if (drops != 0) begin n_fail++; $display("FAIL no_tmo_wait got %0d bad cycles of 120 exp=0", drops); end
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55; sample();
        next_cycle(); mem_ack_i = 1'b0; sample();
        n_checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h55 || err_o !== 1'b0) begin n_fail++; $display("FAIL no_tmo_done got drv=%b data=%h err=%b exp=1/55/0", d_rvalid_o, d_rdata_o, err_o); end
        next_cycle(); sample();
        $display("long load addr=00000040 data=%h err=%b", d_rdata_o, err_o);
`endif
    endtask

    task automatic test_reset_mid();
        next_cycle(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600; sample();
        n_checks++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=1", d_gnt_o); end
        next_cycle(); d_req_i = 1'b0; sample();
        next_cycle(); rst = 1'b0; mem_rdata_i = 32'h99; sample();
        n_checks++; if (d_gnt_o !== 1'b0 || if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt_in_rst got=%b/%b exp=0/0", d_gnt_o, if_gnt_o); end
        next_cycle(); rst = 1'b1; mem_rdata_i = 32'h0; sample();
        n_checks++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || d_rvalid_o !== 1'b0 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL rmid_after got req=%b busy=%b drv=%b err=%b exp=0/0/0/0", mem_req_o, busy_o, d_rvalid_o, err_o); end
        n_checks++; if (d_rdata_o !== 32'h0 || if_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata got=%h/%h exp=0/0", d_rdata_o, if_rdata_o); end
        next_cycle(); if_req_i = 1'b1; if_addr_i = 32'h700; sample();
        n_checks++; if (if_gnt_o !== 1'b1 || d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_fetch_gnt got gnt=%b drv=%b exp=1/0", if_gnt_o, d_rvalid_o); end
        next_cycle(); if_req_i = 1'b0; sample();
        n_checks++; if (mem_addr_o !== 32'h700 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rmid_fetch_mem got addr=%h we=%b exp=700/0", mem_addr_o, mem_we_o); end
        next_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0000006F; sample();
        next_cycle(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; sample();
        n_checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0000006F) begin n_fail++; $display("FAIL rmid_fetch_resp got rv=%b data=%h exp=1/0000006f", if_rvalid_o, if_rdata_o); end
        next_cycle(); sample();
        $display("reset mid-transaction, then fetch addr=00000700 data=%h", if_rdata_o);
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_simultaneous();
        test_stray_and_immediate_ack();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
